// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART TX arbiter
package uart_pkg;

  localparam int DEFAULT_DATA_W = 8;
  // one bit time at 9600 baud from a 50 MHz sysclk
  localparam int BAUD_CYCLES = 5208;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } uart_arb_state_t;

endpackage

// File: rtl/uart_hold_buf.sv
// rtl/uart_hold_buf.sv - one-entry valid/ready holding register for a TX requester
module uart_hold_buf
  import uart_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              clear,
  output logic              full,
  output logic [DATA_W-1:0] data
);

  assign in_ready = ~full;

  // clear only arrives while full, and accept only while empty, so they never collide
  always_ff @(posedge sysclk) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (in_valid && !full) begin
      full <= 1'b1;
      data <= in_data;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART TX core; UART_ARB_STATS_EN adds sent counters
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int DATA_W        = DEFAULT_DATA_W,
  parameter int GAP_CYCLES    = BAUD_CYCLES,
  parameter int START_TIMEOUT = 16
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  output logic              grant,
  output logic              active,
  output logic              err_timeout
`ifdef UART_ARB_STATS_EN
  ,
  output logic [15:0]       sent0_cnt,
  output logic [15:0]       sent1_cnt
`endif
);

  localparam int WAIT_W = $clog2(START_TIMEOUT + 1);
  localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  uart_arb_state_t   state, state_nxt;
  logic              last_grant;
  logic [WAIT_W-1:0] wait_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              full0, full1;
  logic [DATA_W-1:0] buf0_data, buf1_data;
  logic              sel, do_grant, timeout, byte_done;

  uart_hold_buf #(.DATA_W(DATA_W)) u_buf0 (
    .sysclk   (sysclk),
    .reset    (reset),
    .in_valid (req0_valid),
    .in_data  (req0_data),
    .in_ready (req0_ready),
    .clear    (do_grant & ~sel),
    .full     (full0),
    .data     (buf0_data)
  );

  uart_hold_buf #(.DATA_W(DATA_W)) u_buf1 (
    .sysclk   (sysclk),
    .reset    (reset),
    .in_valid (req1_valid),
    .in_data  (req1_data),
    .in_ready (req1_ready),
    .clear    (do_grant & sel),
    .full     (full1),
    .data     (buf1_data)
  );

  assign tx_start  = (state == START);
  assign active    = (state != IDLE);
  assign byte_done = (state == WAIT_DONE) && !tx_busy;

  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    timeout   = 1'b0;
    // with both full, the requester not served last time wins
    sel       = (full0 && full1) ? ~last_grant : full1;
    case (state)
      IDLE: begin
        if (full0 || full1) begin
          do_grant  = 1'b1;
          state_nxt = START;
        end
      end
      START:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (wait_cnt >= WAIT_W'(START_TIMEOUT - 1)) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // wait_cnt counts from the START cycle so the timeout lands START_TIMEOUT cycles after tx_start
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state       <= IDLE;
      tx_data     <= '0;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      err_timeout <= 1'b0;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (do_grant) begin
        tx_data    <= sel ? buf1_data : buf0_data;
        grant      <= sel;
        last_grant <= sel;
        wait_cnt   <= '0;
      end
      if (state == START || state == WAIT_BUSY) wait_cnt <= wait_cnt + 1'b1;
      if (timeout) err_timeout <= 1'b1;
      if (byte_done) gap_cnt <= GAP_W'(GAP_CYCLES - 1);
      else if (state == GAP) gap_cnt <= gap_cnt - 1'b1;
    end
  end

`ifdef UART_ARB_STATS_EN
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sent0_cnt <= '0;
      sent1_cnt <= '0;
    end else if (byte_done) begin
      if (grant) sent1_cnt <= sent1_cnt + 16'd1;
      else       sent0_cnt <= sent0_cnt + 16'd1;
    end
  end
`endif

endmodule
